ram_arbiter: RTL and testbench

- Sequential arbiter sharing the single RAM port among the instruction and data ports of CPUS cores.
- Data ports take priority over instruction ports. Each class is round-robin across CPUs.
- A starvation counter guarantees instruction progress.
- Sits between the per-core caches and the RAM model, and replaces the combinational I/D mux in the memory controller for multicore builds.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/ram_arbiter_rr_pick.sv | 29 ++
 rtl/ram_arbiter.sv | 151 +++++++++++++++
 tb/tb_ram_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake states plus the arbiter FSM and grant-class enums.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, GRANT, RETRY} arb_state_t;

  typedef enum logic {ICLASS, DCLASS} arb_class_t;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Round-robin picker: rotates the request vector to start at start_i and returns the first set index.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] start_i,
  output logic          valid_o,
  output logic [PW-1:0] idx_o
);

  logic [N-1:0]  rot;
  logic [PW-1:0] off;
  logic [PW:0]   sum;

  always_comb begin
    rot     = N'({req_i, req_i} >> start_i);
    valid_o = |rot;
    off     = '0;
    // Descending scan so the lowest offset from the start pointer wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = PW'(i);
    end
    sum = {1'b0, start_i} + {1'b0, off};
    if (sum >= (PW + 1)'(N)) sum = sum - (PW + 1)'(N);
    idx_o = sum[PW-1:0];
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port among CPUS data and instruction ports; data first, round-robin per class,
// with a starvation counter that forces an instruction grant after STARVE_LIMIT data grants.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS         = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int WORD_W       = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [CPUS-1:0]             iREN,
  input  logic [CPUS-1:0][WORD_W-1:0] iaddr,
  input  logic [CPUS-1:0]             dREN,
  input  logic [CPUS-1:0]             dWEN,
  input  logic [CPUS-1:0][WORD_W-1:0] daddr,
  input  logic [CPUS-1:0][WORD_W-1:0] dstore,
  output logic [CPUS-1:0]             iwait,
  output logic [CPUS-1:0]             dwait,
  output logic [CPUS-1:0][WORD_W-1:0] iload,
  output logic [CPUS-1:0][WORD_W-1:0] dload,
  output logic [WORD_W-1:0]           ramaddr,
  output logic [WORD_W-1:0]           ramstore,
  output logic                        ramREN,
  output logic                        ramWEN,
  input  logic [WORD_W-1:0]           ramload,
  input  ramstate_t                   ramstate,
  output logic                        ram_err
);

  localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state_q;
  arb_class_t       gclass_q;
  logic [PW-1:0]    gcpu_q;
  logic [PW-1:0]    d_ptr_q;
  logic [PW-1:0]    i_ptr_q;
  logic [SW-1:0]    starve_q;
  logic [WORD_W-1:0] ramaddr_q;
  logic [WORD_W-1:0] ramstore_q;
  logic [WORD_W-1:0] addr_d;
  logic [WORD_W-1:0] store_d;

  logic          d_valid, i_valid;
  logic [PW-1:0] d_idx, i_idx;
  logic          in_grant, g_req, g_done;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    if (p == PW'(CPUS - 1)) return '0;
    return p + 1'b1;
  endfunction

  rr_pick #(.N(CPUS), .PW(PW)) u_dpick (
    .req_i  (dREN | dWEN),
    .start_i(d_ptr_q),
    .valid_o(d_valid),
    .idx_o  (d_idx)
  );

  rr_pick #(.N(CPUS), .PW(PW)) u_ipick (
    .req_i  (iREN),
    .start_i(i_ptr_q),
    .valid_o(i_valid),
    .idx_o  (i_idx)
  );

  assign in_grant = (state_q == GRANT);
  assign g_req    = (gclass_q == DCLASS) ? (dREN[gcpu_q] | dWEN[gcpu_q]) : iREN[gcpu_q];
  assign g_done   = in_grant && g_req && (ramstate == ACCESS);
  assign ram_err  = in_grant && g_req && (ramstate == ERROR);

  // Address/data follow the grant live; outside GRANT they hold the last driven value.
  always_comb begin
    addr_d  = ramaddr_q;
    store_d = ramstore_q;
    ramREN  = 1'b0;
    ramWEN  = 1'b0;
    if (in_grant) begin
      if (gclass_q == DCLASS) begin
        addr_d  = daddr[gcpu_q];
        store_d = dstore[gcpu_q];
        ramREN  = dREN[gcpu_q];
        ramWEN  = dWEN[gcpu_q];
      end else begin
        addr_d  = iaddr[gcpu_q];
        ramREN  = iREN[gcpu_q];
      end
    end
  end

  assign ramaddr  = addr_d;
  assign ramstore = store_d;
  assign iload    = {CPUS{ramload}};
  assign dload    = {CPUS{ramload}};

  always_comb begin
    iwait = '1;
    dwait = '1;
    if (g_done) begin
      if (gclass_q == DCLASS) dwait[gcpu_q] = 1'b0;
      else                    iwait[gcpu_q] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      gclass_q   <= ICLASS;
      gcpu_q     <= '0;
      d_ptr_q    <= '0;
      i_ptr_q    <= '0;
      starve_q   <= '0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
    end else begin
      ramaddr_q  <= addr_d;
      ramstore_q <= store_d;
      case (state_q)
        IDLE: begin
          if (d_valid || i_valid) begin
            state_q <= GRANT;
            if ((starve_q == SW'(STARVE_LIMIT) && i_valid) || !d_valid) begin
              gclass_q <= ICLASS;
              gcpu_q   <= i_idx;
              starve_q <= '0;
            end else begin
              gclass_q <= DCLASS;
              gcpu_q   <= d_idx;
              if (i_valid && starve_q != SW'(STARVE_LIMIT)) starve_q <= starve_q + 1'b1;
            end
          end
        end
        GRANT: begin
          if (!g_req) begin
            state_q <= IDLE;
          end else if (ramstate == ACCESS) begin
            state_q <= IDLE;
            if (gclass_q == DCLASS) d_ptr_q <= nextPtr(gcpu_q);
            else                    i_ptr_q <= nextPtr(gcpu_q);
          end else if (ramstate == ERROR) begin
            state_q <= RETRY;
          end
        end
        RETRY:   state_q <= GRANT;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter: single read, data round-robin, starvation,
// error retry, abort and reset-during-grant, with the bench acting as the RAM.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;
  localparam int W    = 32;

  logic                   CLK;
  logic                   RST;
  logic [CPUS-1:0]        iREN, dREN, dWEN;
  logic [CPUS-1:0][W-1:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]        iwait, dwait;
  logic [CPUS-1:0][W-1:0] iload, dload;
  logic [W-1:0]           ramaddr, ramstore, ramload;
  logic                   ramREN, ramWEN, ram_err;
  ramstate_t              ramstate;

  int testCount = 0;
  int failCount = 0;

  ram_arbiter #(.CPUS(CPUS), .STARVE_LIMIT(4), .WORD_W(W)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic applyStimulus(input logic [1:0] ir, input logic [1:0] dr, input logic [1:0] dw);
    iREN = ir;
    dREN = dr;
    dWEN = dw;
  endtask

  task automatic applyReset();
    RST = 1'b1;
    applyStimulus(2'b00, 2'b00, 2'b00);
    ramstate = FREE;
    step();
    step();
    RST = 1'b0;
  endtask

  // One grant answered with ACCESS in its first cycle, then the idle turnaround cycle.
  task automatic grantCycle(input string tag, input logic expRen, input logic expWen,
                            input logic [W-1:0] expAddr, input logic [W-1:0] expStore,
                            input logic [1:0] expIwait, input logic [1:0] expDwait);
    step();
    checkOutput({tag, ".ren"},   64'(ramREN),   64'(expRen));
    checkOutput({tag, ".wen"},   64'(ramWEN),   64'(expWen));
    checkOutput({tag, ".addr"},  64'(ramaddr),  64'(expAddr));
    checkOutput({tag, ".store"}, 64'(ramstore), 64'(expStore));
    ramstate = ACCESS;
    #1;
    checkOutput({tag, ".iwait"}, 64'(iwait), 64'(expIwait));
    checkOutput({tag, ".dwait"}, 64'(dwait), 64'(expDwait));
    step();
    ramstate = FREE;
    #1;
    checkOutput({tag, ".idle_ren"}, 64'(ramREN), 64'd0);
    checkOutput({tag, ".idle_wen"}, 64'(ramWEN), 64'd0);
  endtask

  initial begin
    RST = 1'b1;
    applyStimulus(2'b00, 2'b00, 2'b00);
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    ramstate = FREE;
    applyReset();

    // Reset state
    checkOutput("rst.iwait",    64'(iwait),    64'h3);
    checkOutput("rst.dwait",    64'(dwait),    64'h3);
    checkOutput("rst.ren",      64'(ramREN),   64'd0);
    checkOutput("rst.wen",      64'(ramWEN),   64'd0);
    checkOutput("rst.addr",     64'(ramaddr),  64'd0);
    checkOutput("rst.store",    64'(ramstore), 64'd0);
    checkOutput("rst.err",      64'(ram_err),  64'd0);

    // Single data read, ACCESS two cycles after ramREN
    daddr[0] = 32'h100;
    applyStimulus(2'b00, 2'b01, 2'b00);
    #1;
    checkOutput("rd.pre_ren", 64'(ramREN), 64'd0);
    step();
    checkOutput("rd.ren",    64'(ramREN),  64'd1);
    checkOutput("rd.addr",   64'(ramaddr), 64'h100);
    checkOutput("rd.dwait0", 64'(dwait),   64'h3);
    ramstate = BUSY;
    step();
    checkOutput("rd.dwait1", 64'(dwait),   64'h3);
    checkOutput("rd.ren1",   64'(ramREN),  64'd1);
    step();
    ramstate = ACCESS;
    ramload  = 32'hDEADBEEF;
    #1;
    checkOutput("rd.dwait2", 64'(dwait),    64'h2);
    checkOutput("rd.dload",  64'(dload[0]), 64'hDEADBEEF);
    checkOutput("rd.iwait",  64'(iwait),    64'h3);
    step();
    applyStimulus(2'b00, 2'b00, 2'b00);
    ramstate = FREE;
    #1;
    checkOutput("rd.idle_ren",  64'(ramREN),      64'd0);
    checkOutput("rd.hold_addr", 64'(ramaddr),     64'h100);
    checkOutput("rd.dwait3",    64'(dwait),       64'h3);
    checkOutput("rd.dptr",      64'(dut.d_ptr_q), 64'd1);

    // Data round-robin with both write ports held
    applyReset();
    daddr[0] = 32'h10;  daddr[1] = 32'h14;
    dstore[0] = 32'hAA; dstore[1] = 32'hBB;
    applyStimulus(2'b00, 2'b00, 2'b11);
    grantCycle("rr0", 1'b0, 1'b1, 32'h10, 32'hAA, 2'b11, 2'b10);
    checkOutput("rr0.hold_store", 64'(ramstore), 64'hAA);
    grantCycle("rr1", 1'b0, 1'b1, 32'h14, 32'hBB, 2'b11, 2'b01);
    grantCycle("rr2", 1'b0, 1'b1, 32'h10, 32'hAA, 2'b11, 2'b10);
    applyStimulus(2'b00, 2'b00, 2'b00);

    // Starvation: four data grants, then the pending instruction fetch is forced through
    applyReset();
    dstore = '0;
    daddr[0] = 32'h300; daddr[1] = 32'h304; iaddr[1] = 32'h200;
    applyStimulus(2'b10, 2'b11, 2'b00);
    grantCycle("sv0", 1'b1, 1'b0, 32'h300, 32'h0, 2'b11, 2'b10);
    grantCycle("sv1", 1'b1, 1'b0, 32'h304, 32'h0, 2'b11, 2'b01);
    grantCycle("sv2", 1'b1, 1'b0, 32'h300, 32'h0, 2'b11, 2'b10);
    grantCycle("sv3", 1'b1, 1'b0, 32'h304, 32'h0, 2'b11, 2'b01);
    checkOutput("sv.cnt4", 64'(dut.starve_q), 64'd4);
    grantCycle("sv4", 1'b1, 1'b0, 32'h200, 32'h0, 2'b01, 2'b11);
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("sv.cnt0", 64'(dut.starve_q), 64'd0);
    checkOutput("sv.iptr", 64'(dut.i_ptr_q),  64'd0);

    // Error retry on an instruction grant
    applyReset();
    iaddr[0] = 32'h400;
    applyStimulus(2'b01, 2'b00, 2'b00);
    step();
    checkOutput("er.ren",  64'(ramREN),  64'd1);
    checkOutput("er.addr", 64'(ramaddr), 64'h400);
    ramstate = ERROR;
    #1;
    checkOutput("er.err",    64'(ram_err), 64'd1);
    checkOutput("er.iwait0", 64'(iwait),   64'h3);
    step();
    ramstate = FREE;
    #1;
    checkOutput("er.retry_ren", 64'(ramREN),      64'd0);
    checkOutput("er.err_pulse", 64'(ram_err),     64'd0);
    checkOutput("er.iwait1",    64'(iwait),       64'h3);
    checkOutput("er.state",     64'(dut.state_q), 64'(RETRY));
    step();
    checkOutput("er.reissue_ren",  64'(ramREN),  64'd1);
    checkOutput("er.reissue_addr", 64'(ramaddr), 64'h400);
    checkOutput("er.iwait2",       64'(iwait),   64'h3);
    ramstate = ACCESS;
    ramload  = 32'h1234_5678;
    #1;
    checkOutput("er.iwait3", 64'(iwait),    64'h2);
    checkOutput("er.iload",  64'(iload[0]), 64'h1234_5678);
    step();
    ramstate = FREE;
    applyStimulus(2'b00, 2'b00, 2'b00);
    #1;
    checkOutput("er.iptr", 64'(dut.i_ptr_q), 64'd1);

    // Abort: granted data port drops its request before ACCESS
    applyReset();
    daddr[1] = 32'h500;
    applyStimulus(2'b00, 2'b10, 2'b00);
    step();
    checkOutput("ab.ren", 64'(ramREN), 64'd1);
    ramstate = BUSY;
    applyStimulus(2'b00, 2'b00, 2'b00);
    #1;
    checkOutput("ab.drop_ren", 64'(ramREN), 64'd0);
    checkOutput("ab.dwait",    64'(dwait),  64'h3);
    step();
    ramstate = FREE;
    checkOutput("ab.state", 64'(dut.state_q), 64'(IDLE));
    checkOutput("ab.dptr",  64'(dut.d_ptr_q), 64'd0);

    // Reset during a grant, after an instruction grant moved i_ptr
    iaddr[0] = 32'h600;
    applyStimulus(2'b01, 2'b00, 2'b00);
    grantCycle("pre", 1'b1, 1'b0, 32'h600, 32'h0, 2'b10, 2'b11);
    checkOutput("pre.iptr", 64'(dut.i_ptr_q), 64'd1);
    daddr[0] = 32'h700;
    applyStimulus(2'b00, 2'b01, 2'b00);
    step();
    checkOutput("rg.ren", 64'(ramREN), 64'd1);
    RST = 1'b1;
    step();
    checkOutput("rg.ren0",  64'(ramREN),      64'd0);
    checkOutput("rg.wen0",  64'(ramWEN),      64'd0);
    checkOutput("rg.iwait", 64'(iwait),       64'h3);
    checkOutput("rg.dwait", 64'(dwait),       64'h3);
    checkOutput("rg.dptr",  64'(dut.d_ptr_q), 64'd0);
    checkOutput("rg.iptr",  64'(dut.i_ptr_q), 64'd0);
    checkOutput("rg.addr",  64'(ramaddr),     64'd0);
    RST = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b00);
    step();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
